seg7_scan_driver: RTL and testbench

Drives the Nexys2 four-digit multiplexed seven-segment display from a 16-bit hex value. It generates its own scan rate from `clk` and keeps the 2-bit digit pointer internally. It decodes the selected nibble to active-low cathodes and drives active-low anodes with a dead-time gap between digits to suppress ghosting. New values are staged and committed only at a frame boundary, so a digit update never tears mid-scan.

---
 rtl/seg7_pkg.sv | 25 ++
 rtl/seg7_decode.sv | 12 +
 rtl/seg7_scan_driver.sv | 126 ++++++++++++
 tb/tb_seg7_scan_driver.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the Nexys2 seven-segment scan driver.
// Segment patterns are active-low, bit0 = a .. bit6 = g.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF   = 7'b1111111;
  localparam logic [3:0] ANODE_OFF = 4'b1111;

  localparam logic [0:15][6:0] SEG_LUT = {
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_e;

  typedef struct packed {
    logic [3:0]  dp;
    logic [15:0] val;
  } disp_t;

endpackage

// File: rtl/seg7_decode.sv
// Hex nibble to active-low seven-segment pattern.
// Purely combinational; glyphs come from seg7_pkg.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = SEG_LUT[nib];

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed 7-seg scanner with dead time and frame-aligned commit.
// Define SEG7_LZB_EN to enable leading-zero blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int PRESCALE = 12500,
  parameter int DEAD     = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        load,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame
);

  localparam int SW = $clog2(PRESCALE);
  localparam logic [SW-1:0] SC_MAX  = SW'(PRESCALE - 1);
  localparam logic [SW-1:0] DEAD_M1 = SW'(DEAD - 1);

  logic [SW-1:0] sc_q, sc_d;
  logic [1:0]    ptr_q, ptr_d;
  state_e        state_q, state_d;
  disp_t         disp_q, disp_d;
  disp_t         pend_q, pend_d;
  logic          pend_v_q, pend_v_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          frame_q, frame_d;

  logic          slot_wrap;
  logic          frame_wrap;
  logic [3:0]    nib;
  logic [6:0]    glyph;
  logic          lzb;

  assign slot_wrap  = (sc_q == SC_MAX);
  assign frame_wrap = slot_wrap && (ptr_q == 2'd3);
  assign nib        = 4'(disp_q.val >> {ptr_q, 2'b00});

`ifdef SEG7_LZB_EN
  assign lzb = (ptr_q != 2'd0) &&
               ((disp_q.val >> {ptr_q, 2'b00}) == 16'h0);
`else
  assign lzb = 1'b0;
`endif

  seg7_decode u_dec (
    .nib (nib),
    .seg (glyph)
  );

  always_comb begin
    sc_d    = slot_wrap ? '0 : sc_q + SW'(1);
    ptr_d   = slot_wrap ? ptr_q + 2'd1 : ptr_q;
    state_d = state_q;
    unique case (state_q)
      BLANK: if (sc_q == DEAD_M1) state_d = SHOW;
      SHOW:  if (slot_wrap)       state_d = BLANK;
      default: state_d = BLANK;
    endcase
  end

  // A load coinciding with the frame wrap bypasses the pending register.
  always_comb begin
    disp_d   = disp_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    if (frame_wrap) begin
      pend_v_d = 1'b0;
      if (load)          disp_d = '{dp: dp_in, val: value};
      else if (pend_v_q) disp_d = pend_q;
    end else if (load) begin
      pend_d   = '{dp: dp_in, val: value};
      pend_v_d = 1'b1;
    end
  end

  always_comb begin
    an_d    = ANODE_OFF;
    seg_d   = SEG_OFF;
    dp_d    = 1'b1;
    frame_d = frame_wrap;
    if (state_q == SHOW) begin
      an_d  = ~(4'b0001 << ptr_q);
      seg_d = lzb ? SEG_OFF : glyph;
      dp_d  = ~disp_q.dp[ptr_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sc_q     <= '0;
      ptr_q    <= 2'd0;
      state_q  <= BLANK;
      disp_q   <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      an_q     <= ANODE_OFF;
      seg_q    <= SEG_OFF;
      dp_q     <= 1'b1;
      frame_q  <= 1'b0;
    end else begin
      sc_q     <= sc_d;
      ptr_q    <= ptr_d;
      state_q  <= state_d;
      disp_q   <= disp_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      frame_q  <= frame_d;
    end
  end

  assign an    = an_q;
  assign seg   = seg_q;
  assign dp    = dp_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver against a time-indexed display model.
// Build with SEG7_LZB_EN to check leading-zero blanking.
module tb_seg7_scan_driver;

  localparam int P  = 8;
  localparam int D  = 2;
  localparam int FR = 4 * P;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic        load = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state: edges since reset release plus committed/pending contents.
  int          m_k = 0;
  logic [15:0] m_disp = 16'h0;
  logic [3:0]  m_ddp = 4'h0;
  logic [15:0] m_pend = 16'h0;
  logic [3:0]  m_pdp = 4'h0;
  bit          m_pv = 1'b0;

  // Lit segments of each hex glyph, by segment letter.
  string glyph [16] = '{
    "abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
    "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"
  };

  always #5 clk = ~clk;

  seg7_scan_driver #(.PRESCALE(P), .DEAD(D)) dut (
    .clk   (clk),
    .rst   (rst),
    .value (value),
    .dp_in (dp_in),
    .load  (load),
    .an    (an),
    .seg   (seg),
    .dp    (dp),
    .frame (frame)
  );

  function automatic logic [6:0] seg_of(input int n);
    string s;
    logic [6:0] r;
    s = glyph[n];
    r = 7'h7F;
    for (int i = 0; i < s.len(); i++) r[int'(s[i]) - 97] = 1'b0;
    return r;
  endfunction

  always @(posedge clk) begin
    obs_t e;
    int s, p, n;
    if (rst) begin
      m_k = 0; m_disp = 16'h0; m_ddp = 4'h0;
      m_pend = 16'h0; m_pdp = 4'h0; m_pv = 1'b0;
      e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, frame: 1'b0};
    end else begin
      s = m_k % P;
      p = (m_k / P) % 4;
      n = (int'(m_disp) / (16 ** p)) % 16;
      e.frame = ((m_k + 1) % FR == 0);
      if (s < D) begin
        e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1;
      end else begin
        e.an  = 4'hF ^ (4'h1 << p);
        e.seg = seg_of(n);
`ifdef SEG7_LZB_EN
        if (p >= 1 && int'(m_disp) / (16 ** p) == 0) e.seg = 7'h7F;
`endif
        e.dp = !m_ddp[p];
      end
      if ((m_k + 1) % FR == 0) begin
        if (load) begin
          m_disp = value; m_ddp = dp_in;
        end else if (m_pv) begin
          m_disp = m_pend; m_ddp = m_pdp;
        end
        m_pv = 1'b0;
      end else if (load) begin
        m_pend = value; m_pdp = dp_in; m_pv = 1'b1;
      end
      m_k++;
    end
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    obs_t a, e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{an: an, seg: seg, dp: dp, frame: frame};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs t=%0t: got an=%b seg=%b dp=%b frame=%b, want an=%b seg=%b dp=%b frame=%b",
                 $time, a.an, a.seg, a.dp, a.frame, e.an, e.seg, e.dp, e.frame);
      end
      checks++;
      if ($countones(~an) > 1) begin
        errors++;
        $display("FAIL anode_onehot t=%0t: got an=%b, want at most one low", $time, an);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp_in = d;
    load  = 1'b1;
    step(1);
    load  = 1'b0;
  endtask

  // Park so the next edge processes frame position r.
  task automatic align(input int r);
    int guard;
    guard = 0;
    while ((m_k % FR) != r && guard < 2 * FR) begin
      step(1);
      guard++;
    end
    checks++;
    if ((m_k % FR) != r) begin
      errors++;
      $display("FAIL align: got pos %0d, want %0d", m_k % FR, r);
    end
  endtask

  initial begin
    step(3);
    rst = 1'b0;
    step(4);
    do_load(16'h1234, 4'h0);
    step(2 * FR + 4);

    do_load(16'h0000, 4'h0);
    step(FR + 8);
    align(10);
    do_load(16'hABCD, 4'h0);
    step(2 * FR);

    align(3);
    do_load(16'h1111, 4'h0);
    step(5);
    do_load(16'h2222, 4'h0);
    step(2 * FR);

    align(FR - 1);
    do_load(16'h5555, 4'h0);
    step(FR + 2);

    do_load(16'h89EF, 4'b0101);
    step(2 * FR);

    do_load(16'h0070, 4'h0);
    step(2 * FR);
    do_load(16'h0000, 4'h0);
    step(2 * FR);

    for (int i = 0; i < 300; i++) begin
      load  = ($urandom % 6 == 0);
      value = 16'($urandom);
      dp_in = 4'($urandom);
      step(1);
    end
    load = 1'b0;
    step(FR);

    align(13);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(2 * FR);
    do_load(16'h0C0D, 4'b1000);
    step(2 * FR + 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
